// File: rtl/sd_emmc_adma2_ctrl.sv
// ADMA2 descriptor engine: fetches 8-byte descriptors over AXI, follows links and
// hands transfer segments to the SDMA/AXI data mover, reporting SDHC ADMA error state.
module sd_emmc_adma2_ctrl #(
  parameter int unsigned DESC_ADDR_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   adma_start,
  input  logic [DESC_ADDR_W-1:0] adma_desc_base,
  input  logic                   adma_abort,
  output logic [DESC_ADDR_W-1:0] desc_araddr,
  output logic                   desc_arvalid,
  input  logic                   desc_arready,
  input  logic [31:0]            desc_rdata,
  input  logic                   desc_rvalid,
  input  logic                   desc_rlast,
  output logic                   desc_rready,
  output logic [DESC_ADDR_W-1:0] seg_addr,
  output logic [16:0]            seg_len,
  output logic                   seg_valid,
  input  logic                   seg_done,
  output logic                   adma_int,
  output logic                   adma_done,
  output logic                   adma_err_int,
  output logic [1:0]             adma_err_state,
  output logic                   adma_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StFetchAr,
    StFetchR,
    StDecode,
    StTran,
    StNext,
    StError
  } state_e;

  localparam logic [1:0] ActTran = 2'b10;
  localparam logic [1:0] ActLink = 2'b11;
  localparam logic [1:0] ErrFds  = 2'b01;
  localparam logic [1:0] ErrTfr  = 2'b11;

  state_e                 state_q, state_d;
  logic [DESC_ADDR_W-1:0] desc_ptr_q, desc_ptr_d;
  logic                   beat_q, beat_d;
  logic                   drain_q, drain_d;
  logic                   d_valid_q, d_valid_d;
  logic                   d_end_q, d_end_d;
  logic                   d_int_q, d_int_d;
  logic [1:0]             d_act_q, d_act_d;
  logic [15:0]            d_len_q, d_len_d;
  logic [31:0]            word1_q, word1_d;
  logic [DESC_ADDR_W-1:0] seg_addr_q, seg_addr_d;
  logic [16:0]            seg_len_q, seg_len_d;
  logic                   int_q, int_d;
  logic [1:0]             err_state_q, err_state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      desc_ptr_q  <= '0;
      beat_q      <= 1'b0;
      drain_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_end_q     <= 1'b0;
      d_int_q     <= 1'b0;
      d_act_q     <= 2'b00;
      d_len_q     <= 16'h0;
      word1_q     <= 32'h0;
      seg_addr_q  <= '0;
      seg_len_q   <= 17'h0;
      int_q       <= 1'b0;
      err_state_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      desc_ptr_q  <= desc_ptr_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      d_valid_q   <= d_valid_d;
      d_end_q     <= d_end_d;
      d_int_q     <= d_int_d;
      d_act_q     <= d_act_d;
      d_len_q     <= d_len_d;
      word1_q     <= word1_d;
      seg_addr_q  <= seg_addr_d;
      seg_len_q   <= seg_len_d;
      int_q       <= int_d;
      err_state_q <= err_state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    desc_ptr_d  = desc_ptr_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    d_valid_d   = d_valid_q;
    d_end_d     = d_end_q;
    d_int_d     = d_int_q;
    d_act_d     = d_act_q;
    d_len_d     = d_len_q;
    word1_d     = word1_q;
    seg_addr_d  = seg_addr_q;
    seg_len_d   = seg_len_q;
    int_d       = 1'b0;
    err_state_d = err_state_q;

    // Beats of an abandoned burst are swallowed until its last beat.
    if (drain_q && desc_rvalid && desc_rlast) begin
      drain_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (adma_start && !drain_q) begin
          desc_ptr_d  = adma_desc_base;
          err_state_d = 2'b00;
          state_d     = StFetchAr;
        end
      end
      StFetchAr: begin
        if (desc_arready) begin
          beat_d  = 1'b0;
          state_d = StFetchR;
        end
      end
      StFetchR: begin
        if (desc_rvalid) begin
          if (!beat_q) begin
            d_valid_d = desc_rdata[0];
            d_end_d   = desc_rdata[1];
            d_int_d   = desc_rdata[2];
            d_act_d   = desc_rdata[5:4];
            d_len_d   = desc_rdata[31:16];
            if (desc_rlast) begin
              err_state_d = ErrFds;
              state_d     = StError;
            end else begin
              beat_d = 1'b1;
            end
          end else begin
            word1_d = desc_rdata;
            if (!desc_rlast) begin
              // Burst longer than two beats: flag it and drain the remainder.
              err_state_d = ErrFds;
              drain_d     = 1'b1;
              state_d     = StError;
            end else begin
              state_d = StDecode;
            end
          end
        end
      end
      StDecode: begin
        if (!d_valid_q) begin
          err_state_d = ErrFds;
          state_d     = StError;
        end else if (d_act_q == ActTran) begin
          seg_addr_d = word1_q[DESC_ADDR_W-1:0];
          seg_len_d  = {d_len_q == 16'h0, d_len_q};
          state_d    = StTran;
        end else if (d_act_q == ActLink) begin
          if (word1_q[2:0] != 3'b000) begin
            err_state_d = ErrFds;
            state_d     = StError;
          end else begin
            desc_ptr_d = word1_q[DESC_ADDR_W-1:0];
            state_d    = StFetchAr;
          end
        end else begin
          state_d = StNext;
        end
      end
      StTran: begin
        if (seg_done) begin
          int_d   = d_int_q;
          state_d = StNext;
        end
      end
      StNext: begin
        if (d_end_q) begin
          state_d = StIdle;
        end else begin
          desc_ptr_d = desc_ptr_q + DESC_ADDR_W'(8);
          state_d    = StFetchAr;
        end
      end
      StError: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides whatever the state decided this cycle.
    if (adma_abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      int_d       = 1'b0;
      err_state_d = (state_q == StTran) ? ErrTfr : err_state_q;
      if (state_q == StFetchAr && desc_arready) begin
        drain_d = 1'b1;
      end
      if (state_q == StFetchR) begin
        drain_d = !(desc_rvalid && desc_rlast);
      end
    end
  end

  assign desc_arvalid   = (state_q == StFetchAr);
  assign desc_araddr    = desc_ptr_q;
  assign desc_rready    = (state_q == StFetchR) || drain_q;
  assign seg_valid      = (state_q == StTran);
  assign seg_addr       = seg_addr_q;
  assign seg_len        = seg_len_q;
  assign adma_int       = int_q;
  assign adma_done      = (state_q == StNext) && d_end_q;
  assign adma_err_int   = (state_q == StError);
  assign adma_err_state = err_state_q;
  assign adma_busy      = (state_q != StIdle) || drain_q;

endmodule

// File: tb/tb_sd_emmc_adma2_ctrl.sv
// Bench for sd_emmc_adma2_ctrl: memory-backed AXI slave and segment sink, checked
// against a descriptor-walking reference model.
module tb_sd_emmc_adma2_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        adma_start;
  logic [31:0] adma_desc_base;
  logic        adma_abort;
  logic [31:0] desc_araddr;
  logic        desc_arvalid;
  logic        desc_arready;
  logic [31:0] desc_rdata;
  logic        desc_rvalid;
  logic        desc_rlast;
  logic        desc_rready;
  logic [31:0] seg_addr;
  logic [16:0] seg_len;
  logic        seg_valid;
  logic        seg_done;
  logic        adma_int;
  logic        adma_done;
  logic        adma_err_int;
  logic [1:0]  adma_err_state;
  logic        adma_busy;

  always #5 clock = ~clock;

  sd_emmc_adma2_ctrl #(.DESC_ADDR_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .adma_start     (adma_start),
    .adma_desc_base (adma_desc_base),
    .adma_abort     (adma_abort),
    .desc_araddr    (desc_araddr),
    .desc_arvalid   (desc_arvalid),
    .desc_arready   (desc_arready),
    .desc_rdata     (desc_rdata),
    .desc_rvalid    (desc_rvalid),
    .desc_rlast     (desc_rlast),
    .desc_rready    (desc_rready),
    .seg_addr       (seg_addr),
    .seg_len        (seg_len),
    .seg_valid      (seg_valid),
    .seg_done       (seg_done),
    .adma_int       (adma_int),
    .adma_done      (adma_done),
    .adma_err_int   (adma_err_int),
    .adma_err_state (adma_err_state),
    .adma_busy      (adma_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mem0 [bit [31:0]];
  logic [31:0] mem1 [bit [31:0]];
  bit          fault_en;
  logic [31:0] fault_addr;

  logic [31:0] exp_ar[$], exp_seg_addr[$];
  int          exp_seg_len[$];
  int          exp_int, exp_done, exp_err;
  logic [1:0]  exp_err_state;

  logic [31:0] got_ar[$], got_seg_addr[$];
  int          got_seg_len[$];
  int          got_int, got_done, got_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd0(input logic [31:0] a);
    return mem0.exists(a) ? mem0[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd1(input logic [31:0] a);
    return mem1.exists(a) ? mem1[a] : 32'h0;
  endfunction

  task automatic set_desc(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
    mem0[a] = w0;
    mem1[a] = w1;
  endtask

  // Walks the chain the way the descriptor rules describe it.
  function automatic void model(input logic [31:0] base, input bit abort_seg, input bit abort_r);
    logic [31:0] ptr, w0, w1;
    ptr = base;
    exp_ar.delete();
    exp_seg_addr.delete();
    exp_seg_len.delete();
    exp_int = 0;
    exp_done = 0;
    exp_err = 0;
    exp_err_state = 2'b00;
    for (int step = 0; step < 64; step++) begin
      exp_ar.push_back(ptr);
      if (abort_r) return;
      w0 = rd0(ptr);
      w1 = rd1(ptr);
      if ((fault_en && ptr == fault_addr) || !w0[0]) begin
        exp_err = 1;
        exp_err_state = 2'b01;
        return;
      end
      if (w0[5:4] == 2'b11) begin
        if (w1[2:0] != 3'b000) begin
          exp_err = 1;
          exp_err_state = 2'b01;
          return;
        end
        ptr = w1;
        continue;
      end
      if (w0[5:4] == 2'b10) begin
        exp_seg_addr.push_back(w1);
        exp_seg_len.push_back(w0[31:16] == 16'h0 ? 65536 : int'(w0[31:16]));
        if (abort_seg) begin
          exp_err_state = 2'b11;
          return;
        end
        if (w0[2]) exp_int++;
      end
      if (w0[1]) begin
        exp_done = 1;
        return;
      end
      ptr = ptr + 32'd8;
    end
  endfunction

  task automatic run(input logic [31:0] base, input bit abort_seg, input bit abort_r,
                     input int stall_fixed, input bit noise);
    logic [31:0] rq_data[$];
    bit          rq_last[$];
    bit          pop_pending = 1'b0;
    int          stall_cnt;
    bit          seg_active = 1'b0;
    int          seg_delay = 0;
    bit          r_abort_live = 1'b0;
    bit          ar_wait = 1'b0;
    logic [31:0] ar_hold = 32'h0;
    int          cyc;
    int          err_cyc = -10;
    logic [31:0] a;

    model(base, abort_seg, abort_r);
    got_ar.delete();
    got_seg_addr.delete();
    got_seg_len.delete();
    got_int = 0;
    got_done = 0;
    got_err = 0;
    stall_cnt = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 2));

    @(negedge clock);
    adma_start = 1'b1;
    adma_desc_base = base;
    @(negedge clock);
    adma_start = 1'b0;

    for (cyc = 0; cyc < 3000; cyc++) begin
      if (pop_pending) begin
        void'(rq_data.pop_front());
        void'(rq_last.pop_front());
        pop_pending = 1'b0;
      end
      if (adma_int) got_int++;
      if (adma_done) got_done++;
      if (adma_err_int) begin
        got_err++;
        err_cyc = cyc;
      end
      if (ar_wait) begin
        check("ar_hold_valid", desc_arvalid, 1);
        check("ar_hold_addr", desc_araddr, ar_hold);
      end
      if (r_abort_live && rq_data.size() != 0) begin
        check("drain_rready", desc_rready, 1);
        check("drain_busy", adma_busy, 1);
      end
      if (!adma_busy) break;

      adma_start = 1'b0;
      adma_abort = 1'b0;
      seg_done = 1'b0;
      if (noise && $urandom_range(0, 19) == 0) begin
        adma_start = 1'b1;
        adma_desc_base = 32'hdead_0000;
      end

      if (rq_data.size() != 0 && (desc_rvalid || $urandom_range(0, 3) != 0)) begin
        desc_rvalid = 1'b1;
        desc_rdata = rq_data[0];
        desc_rlast = rq_last[0];
        pop_pending = desc_rready;
      end else begin
        desc_rvalid = 1'b0;
        desc_rlast = 1'b0;
        desc_rdata = $urandom;
      end
      if (abort_r && desc_rready && !r_abort_live) begin
        adma_abort = 1'b1;
        r_abort_live = 1'b1;
      end

      if (desc_arvalid) begin
        if (stall_cnt > 0) begin
          desc_arready = 1'b0;
          stall_cnt--;
          ar_wait = 1'b1;
          ar_hold = desc_araddr;
        end else begin
          desc_arready = 1'b1;
          ar_wait = 1'b0;
          a = desc_araddr;
          got_ar.push_back(a);
          if (fault_en && a == fault_addr) begin
            rq_data.push_back(rd0(a));
            rq_last.push_back(1'b1);
          end else begin
            rq_data.push_back(rd0(a));
            rq_last.push_back(1'b0);
            rq_data.push_back(rd1(a));
            rq_last.push_back(1'b1);
          end
          stall_cnt = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 2));
        end
      end else begin
        desc_arready = 1'($urandom_range(0, 1));
        ar_wait = 1'b0;
      end

      if (seg_valid) begin
        if (!seg_active) begin
          seg_active = 1'b1;
          got_seg_addr.push_back(seg_addr);
          got_seg_len.push_back(int'(seg_len));
          seg_delay = int'($urandom_range(0, 4));
        end
        if (seg_delay == 0) begin
          seg_done = 1'b1;
          seg_active = 1'b0;
          if (abort_seg) adma_abort = 1'b1;
        end else begin
          seg_delay--;
        end
      end else if (noise && $urandom_range(0, 9) == 0) begin
        seg_done = 1'b1;
      end
      @(negedge clock);
    end

    adma_start = 1'b0;
    adma_abort = 1'b0;
    seg_done = 1'b0;
    desc_rvalid = 1'b0;
    desc_rlast = 1'b0;
    desc_arready = 1'b0;

    check("timeout", cyc < 3000, 1);
    check("r_drained", rq_data.size() - (pop_pending ? 1 : 0), 0);
    check("ar_count", got_ar.size(), exp_ar.size());
    for (int i = 0; i < got_ar.size() && i < exp_ar.size(); i++) check("ar_addr", got_ar[i], exp_ar[i]);
    check("seg_count", got_seg_addr.size(), exp_seg_addr.size());
    for (int i = 0; i < got_seg_addr.size() && i < exp_seg_addr.size(); i++) begin
      check("seg_addr", got_seg_addr[i], exp_seg_addr[i]);
      check("seg_len", got_seg_len[i], exp_seg_len[i]);
    end
    check("int_count", got_int, exp_int);
    check("done_count", got_done, exp_done);
    check("err_count", got_err, exp_err);
    check("err_state", adma_err_state, exp_err_state);
    if (exp_err != 0) check("idle_after_err", cyc - err_cyc, 1);
    check("end_seg_valid", seg_valid, 0);
    check("end_arvalid", desc_arvalid, 0);
    check("end_rready", desc_rready, 0);
  endtask

  task automatic gen_random(output logic [31:0] base);
    logic [31:0] ptr, w1;
    logic [15:0] len;
    logic [1:0]  act;
    bit          last, end_b, stop;
    int          n, k;
    mem0.delete();
    mem1.delete();
    fault_en = 1'b0;
    base = 32'($urandom_range(16, 4095)) << 16;
    ptr = base;
    n = int'($urandom_range(1, 5));
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) begin
      last = (i == n - 1);
      k = int'($urandom_range(0, 9));
      len = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      w1 = $urandom;
      end_b = 1'b0;
      if (!last && k < 2) begin
        act = 2'b11;
        w1 = ptr + 32'h100;
        end_b = 1'($urandom_range(0, 1));
      end else if (k == 2 || (last && k < 4)) begin
        act = 2'($urandom_range(0, 1));
        end_b = last;
      end else begin
        act = 2'b10;
        end_b = last;
      end
      if (k == 3 && !last && $urandom_range(0, 1) == 1) begin
        set_desc(ptr, {len, 10'($urandom), act, 1'b0, 1'($urandom), 1'b0, 1'b0}, w1);
        stop = 1'b1;
      end else begin
        set_desc(ptr, {len, 10'($urandom), act, 1'($urandom), 1'($urandom), end_b, 1'b1}, w1);
        ptr = (act == 2'b11) ? w1 : ptr + 32'd8;
      end
    end
  endtask

  initial begin
    logic [31:0] rbase;
    reset = 1'b1;
    adma_start = 1'b0;
    adma_desc_base = 32'h0;
    adma_abort = 1'b0;
    desc_arready = 1'b0;
    desc_rdata = 32'h0;
    desc_rvalid = 1'b0;
    desc_rlast = 1'b0;
    seg_done = 1'b0;
    fault_en = 1'b0;
    fault_addr = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);

    check("rst_arvalid", desc_arvalid, 0);
    check("rst_araddr", desc_araddr, 0);
    check("rst_rready", desc_rready, 0);
    check("rst_seg_valid", seg_valid, 0);
    check("rst_seg_addr", seg_addr, 0);
    check("rst_seg_len", seg_len, 0);
    check("rst_int", adma_int, 0);
    check("rst_done", adma_done, 0);
    check("rst_err_int", adma_err_int, 0);
    check("rst_err_state", adma_err_state, 0);
    check("rst_busy", adma_busy, 0);

    // Single tran, End, Int
    mem0.delete(); mem1.delete();
    set_desc(32'h1000, 32'h0200_0027, 32'h8000_0000);
    run(32'h1000, 1'b0, 1'b0, -1, 1'b0);

    // tran, nop, tran(End, Length=0)
    mem0.delete(); mem1.delete();
    set_desc(32'h1000, 32'h0100_0021, 32'h9000_0000);
    set_desc(32'h1008, 32'h0000_0001, 32'h0);
    set_desc(32'h1010, 32'h0000_0023, 32'ha000_0000);
    run(32'h1000, 1'b0, 1'b0, -1, 1'b0);

    // Link 0x2000 -> 0x3000, then tran End
    mem0.delete(); mem1.delete();
    set_desc(32'h2000, 32'h0000_0031, 32'h0000_3000);
    set_desc(32'h3000, 32'h0040_0023, 32'hb000_0000);
    run(32'h2000, 1'b0, 1'b0, -1, 1'b0);

    // Valid=0
    mem0.delete(); mem1.delete();
    set_desc(32'h4000, 32'h0000_0022, 32'hc000_0000);
    run(32'h4000, 1'b0, 1'b0, -1, 1'b0);

    // Abort mid-TRAN together with seg_done
    mem0.delete(); mem1.delete();
    set_desc(32'h5000, 32'h0080_0025, 32'hd000_0000);
    run(32'h5000, 1'b1, 1'b0, -1, 1'b0);

    // AR backpressure for 10 cycles, rlast on beat 1
    mem0.delete(); mem1.delete();
    set_desc(32'h6000, 32'h0010_0023, 32'he000_0000);
    fault_en = 1'b1;
    fault_addr = 32'h6000;
    run(32'h6000, 1'b0, 1'b0, 10, 1'b0);
    fault_en = 1'b0;

    // Abort while in FETCH_R: burst is drained
    mem0.delete(); mem1.delete();
    set_desc(32'h7000, 32'h0010_0023, 32'hf000_0000);
    run(32'h7000, 1'b0, 1'b1, 0, 1'b0);

    // Misaligned link target
    mem0.delete(); mem1.delete();
    set_desc(32'h2000, 32'h0000_0031, 32'h0000_3004);
    run(32'h2000, 1'b0, 1'b0, -1, 1'b0);

    // Descriptor pointer wraps at 32 bits
    mem0.delete(); mem1.delete();
    set_desc(32'hffff_fff8, 32'h0000_0001, 32'h0);
    set_desc(32'h0000_0000, 32'h0010_0027, 32'h1234_5678);
    run(32'hffff_fff8, 1'b0, 1'b0, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      gen_random(rbase);
      run(rbase, 1'b0, 1'b0, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
